panel_test_seq: RTL and testbench
=================================

Name: panel_test_seq

Overview:
Parametrised front-panel I/O test sequencer for the PDP8e board bring-up image. It steps a display selection through NSRC sources using next/prev buttons, which are synchronised and rate-limited with auto-repeat. It drives the data-display LEDs from an external source slice or from an internal walking-pattern generator. The generator has left, right, bounce and count modes and is paced by a parametrised tick.

Parameters:
DW, 12, display/data width in bits (>=2)
NSRC, 6, number of selectable sources (>=2)
WALK_IDX, 3, selection index that shows the internal walk pattern (<NSRC)
RESET_SEL, 0, selection index after reset (<NSRC)
TICK_DIV, 65536, clock cycles per walk tick (>=2)
DEB_CNT, 65536, button hold-off cycles after an accepted press (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
next_btn  in  1  raw async button, active-high; step selection forward
prev_btn  in  1  raw async button, active-high; step selection backward
walk_mode  in  2  00 left, 01 right, 10 bounce, 11 binary count
src  in  NSRC*DW  source k = src[k*DW +: DW]; slice WALK_IDX is ignored
ds  out  DW  registered display data
sel_idx  out  clog2(NSRC)  current selection
sel_onehot  out  NSRC  one-hot of sel_idx, bit k = source k
tick  out  1  one-cycle pulse every TICK_DIV cycles
walk  out  DW  current walk-pattern register

Behaviour:
- Reset state: ds=0, sel_idx=RESET_SEL, sel_onehot=1<<RESET_SEL, tick=0, walk=0, bounce dir=up. Tick counter loads TICK_DIV-1, hold counter=0, synchroniser flops=0.
- Reset asserted mid-operation returns every register to its reset value on that edge.
- Button path:
  - Each button passes through a 2-flop synchroniser; decisions use stage 2.
  - Hold counter: when hold==0 and exactly one synced button is high, step the selection and load hold=DEB_CNT.
  - When hold!=0: decrement; all buttons are ignored.
  - Both buttons high: no step, no hold load.
  - Held button auto-repeats, one step every DEB_CNT+1 cycles.
  - Latency: a button sampled high at edge E changes sel_idx at edge E+2.
- Selection arithmetic:
  - next: sel = (sel==NSRC-1) ? 0 : sel+1.
  - prev: sel = (sel==0) ? NSRC-1 : sel-1.
  - sel_onehot updates on the same edge as sel_idx.
- Tick:
  - Down-counter decrements each cycle.
  - At 0: tick=1 for that cycle, reload TICK_DIV-1.
  - First pulse arrives TICK_DIV cycles after reset deassertion. Period is exactly TICK_DIV.
  - Tick runs free regardless of selection.
- Walk update occurs only when tick==1 and sel_idx==WALK_IDX; otherwise walk holds its value. Mode is sampled on the tick, and a mode change takes effect at the next qualifying tick. Bit 0 = LSB.
  - left: walk==0 -> 1; else walk<<1. The MSB shifts out to give 0, so there is one dark tick before 1 reappears.
  - right: walk==0 -> 1<<(DW-1); else walk>>1.
  - bounce:
    - walk==0 -> load 1, dir=up.
    - dir up: if walk[DW-1] then dir=down and walk>>1, else walk<<1.
    - dir down: if walk[0] then dir=up and walk<<1, else walk>>1.
    - The pattern never goes dark once started.
  - count: walk+1 mod 2^DW.
  - A non-one-hot value entering a shift mode is shifted as-is, with the same rules.
- Display: ds <= (sel_idx==WALK_IDX) ? walk : src slice sel_idx, registered with one-cycle latency after sel_idx/walk change.

Test Plan:
Parameters for all scenarios: DW=12, NSRC=6, WALK_IDX=3, RESET_SEL=0, TICK_DIV=4, DEB_CNT=8; src slice k = 12'h100*(k+1).
- Reset release: ds=0, sel_idx=0, sel_onehot=6'b000001, walk=0. tick high on cycle 4, 8, 12; never two consecutive.
- next_btn 1-cycle pulse: sel_idx=1 two edges after sample, sel_onehot=6'b000010, ds=12'h200 one cycle later. next held 30 cycles: sel_idx steps 1,2,3,4 at 9-cycle spacing.
- Wrap and conflict: prev from sel 0 -> 5, ds=12'h600. next from 5 -> 0. Both buttons held 20 cycles -> sel unchanged, hold stays 0.
- sel=3, left mode: walk across ticks 0->1->2->...->12'h800->0->1. Right mode from 0: 12'h800->12'h400. ds tracks walk with 1-cycle lag.
- Bounce from 0: 1,2,...,12'h800,12'h400,...,1,2. Count mode from 12'hFFE: 12'hFFF->0->1.
- Walk freeze and reset:
  - Walk at 12'h020, select 4 -> walk stays 12'h020 across 5 ticks. Return to 3 -> resumes 12'h040.
  - Reset asserted mid-walk -> walk=0, sel_idx=0, ds=0 next edge.

Source files
------------

// File: rtl/panel_test_seq.sv
// Front-panel I/O test sequencer for board bring-up: selects one of NSRC
// display sources with next/prev buttons and drives the data LEDs either
// from an external source slice or from an internal walking-pattern generator.
module panel_test_seq #(
  parameter int DW        = 12,
  parameter int NSRC      = 6,
  parameter int WALK_IDX  = 3,
  parameter int RESET_SEL = 0,
  parameter int TICK_DIV  = 65536,
  parameter int DEB_CNT   = 65536,
  localparam int SW = $clog2(NSRC),
  localparam int TW = $clog2(TICK_DIV),
  localparam int HW = $clog2(DEB_CNT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next_btn,
  input  logic               prev_btn,
  input  logic [1:0]         walk_mode,
  input  logic [NSRC*DW-1:0] src,
  output logic [DW-1:0]      ds,
  output logic [SW-1:0]      sel_idx,
  output logic [NSRC-1:0]    sel_onehot,
  output logic               tick,
  output logic [DW-1:0]      walk
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic          next_s1, next_s2, prev_s1, prev_s2;
  logic [HW-1:0] hold;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] sel_nxt;
  logic          one_btn;
  logic          walk_en;
  logic [DW-1:0] walk_nxt;
  dir_t          dir, dir_nxt;

  // Two-flop synchronisers for the raw asynchronous buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_s1 <= 1'b0;
      next_s2 <= 1'b0;
      prev_s1 <= 1'b0;
      prev_s2 <= 1'b0;
    end else begin
      next_s1 <= next_btn;
      next_s2 <= next_s1;
      prev_s1 <= prev_btn;
      prev_s2 <= prev_s1;
    end
  end

  // Candidate selection for a single pressed button, wrapping at both ends.
  always_comb begin
    sel_nxt = sel_idx;
    one_btn = next_s2 ^ prev_s2;
    if (next_s2 && !prev_s2)
      sel_nxt = (sel_idx == SW'(NSRC - 1)) ? '0 : sel_idx + SW'(1);
    else if (prev_s2 && !next_s2)
      sel_nxt = (sel_idx == '0) ? SW'(NSRC - 1) : sel_idx - SW'(1);
  end

  // Selection register with hold-off counter; a held button auto-repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_idx <= SW'(RESET_SEL);
      hold    <= '0;
    end else if (hold != '0) begin
      hold <= hold - HW'(1);
    end else if (one_btn) begin
      sel_idx <= sel_nxt;
      hold    <= HW'(DEB_CNT);
    end
  end

  assign sel_onehot = NSRC'(1) << sel_idx;

  // Free-running tick divider producing a one-cycle pulse every TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= TW'(TICK_DIV - 1);
      tick     <= 1'b0;
    end else if (tick_cnt == '0) begin
      tick_cnt <= TW'(TICK_DIV - 1);
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt - TW'(1);
      tick     <= 1'b0;
    end
  end

  assign walk_en = tick && (sel_idx == SW'(WALK_IDX));

  // Next walk pattern for the currently requested mode.
  always_comb begin
    walk_nxt = walk;
    dir_nxt  = dir;
    unique case (walk_mode)
      2'b00: walk_nxt = (walk == '0) ? DW'(1) : walk << 1;
      2'b01: walk_nxt = (walk == '0) ? {1'b1, {(DW-1){1'b0}}} : walk >> 1;
      2'b10: begin
        if (walk == '0) begin
          walk_nxt = DW'(1);
          dir_nxt  = DIR_UP;
        end else if (dir == DIR_UP) begin
          if (walk[DW-1]) begin
            dir_nxt  = DIR_DOWN;
            walk_nxt = walk >> 1;
          end else begin
            walk_nxt = walk << 1;
          end
        end else begin
          if (walk[0]) begin
            dir_nxt  = DIR_UP;
            walk_nxt = walk << 1;
          end else begin
            walk_nxt = walk >> 1;
          end
        end
      end
      default: walk_nxt = walk + DW'(1);
    endcase
  end

  // Walk register advances only on a tick while the walk source is shown.
  always_ff @(posedge clk) begin
    if (reset) begin
      walk <= '0;
      dir  <= DIR_UP;
    end else if (walk_en) begin
      walk <= walk_nxt;
      dir  <= dir_nxt;
    end
  end

  // Registered display mux: walk pattern or the selected external slice.
  always_ff @(posedge clk) begin
    if (reset)
      ds <= '0;
    else if (sel_idx == SW'(WALK_IDX))
      ds <= walk;
    else
      ds <= src[int'(sel_idx)*DW +: DW];
  end

endmodule

// File: tb/tb_panel_test_seq.sv
// Directed self-checking bench for panel_test_seq with small tick/hold-off
// parameters so that button repeat and walk patterns are reachable quickly.
module tb_panel_test_seq;

  localparam int DW = 12;
  localparam int NSRC = 6;

  logic               clk;
  logic               reset;
  logic               next_btn;
  logic               prev_btn;
  logic [1:0]         walk_mode;
  logic [NSRC*DW-1:0] src;
  logic [DW-1:0]      ds;
  logic [2:0]         sel_idx;
  logic [NSRC-1:0]    sel_onehot;
  logic               tick;
  logic [DW-1:0]      walk;

  int total = 0;
  int bad = 0;

  panel_test_seq #(
    .DW(DW), .NSRC(NSRC), .WALK_IDX(3), .RESET_SEL(0), .TICK_DIV(4), .DEB_CNT(8)
  ) dut (
    .clk(clk), .reset(reset), .next_btn(next_btn), .prev_btn(prev_btn),
    .walk_mode(walk_mode), .src(src), .ds(ds), .sel_idx(sel_idx),
    .sel_onehot(sel_onehot), .tick(tick), .walk(walk)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic nb, input logic pb, input logic [1:0] mode);
    next_btn  = nb;
    prev_btn  = pb;
    walk_mode = mode;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // One-cycle button pulse; selection must still be old one edge later, new at +2.
  task automatic press(input logic is_next, input logic [2:0] from_sel, input logic [2:0] to_sel);
    applyStimulus(is_next, !is_next, walk_mode);
    step(1);
    applyStimulus(1'b0, 1'b0, walk_mode);
    step(1);
    checkOutput("sel_before", 32'(sel_idx), 32'(from_sel));
    step(1);
    checkOutput("sel_after", 32'(sel_idx), 32'(to_sel));
  endtask

  // Advance until a tick is visible, bounded so a dead divider cannot hang.
  task automatic wait_tick();
    for (int i = 0; i < 8; i++) begin
      if (tick === 1'b1) break;
      step(1);
    end
    checkOutput("tick_wait", 32'(tick), 32'd1);
  endtask

  task automatic walk_step(input logic [DW-1:0] exp);
    wait_tick();
    step(1);
    checkOutput("walk", 32'(walk), 32'(exp));
    step(1);
    checkOutput("ds_walk", 32'(ds), 32'(exp));
  endtask

  initial begin
    logic [2:0] exp_sel;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00);
    for (int k = 0; k < NSRC; k++) src[k*DW +: DW] = DW'(12'h100 * (k + 1));

    // Reset state and tick cadence.
    do_reset();
    checkOutput("rst_ds", 32'(ds), 32'h0);
    checkOutput("rst_sel", 32'(sel_idx), 32'd0);
    checkOutput("rst_onehot", 32'(sel_onehot), 32'b000001);
    checkOutput("rst_walk", 32'(walk), 32'h0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      checkOutput("tick_cadence", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    checkOutput("ds_src0", 32'(ds), 32'h100);

    // Single next pulse.
    $display("[TB] next pulse");
    press(1'b1, 3'd0, 3'd1);
    checkOutput("onehot_1", 32'(sel_onehot), 32'b000010);
    step(1);
    checkOutput("ds_src1", 32'(ds), 32'h200);
    step(10);

    // Held next: auto-repeat every DEB_CNT+1 cycles.
    $display("[TB] next held");
    do_reset();
    applyStimulus(1'b1, 1'b0, 2'b00);
    for (int k = 1; k <= 45; k++) begin
      step(1);
      if (k == 30) applyStimulus(1'b0, 1'b0, 2'b00);
      if (k < 3) exp_sel = 3'd0;
      else if (k < 12) exp_sel = 3'd1;
      else if (k < 21) exp_sel = 3'd2;
      else if (k < 30) exp_sel = 3'd3;
      else exp_sel = 3'd4;
      checkOutput("sel_repeat", 32'(sel_idx), 32'(exp_sel));
    end
    checkOutput("onehot_4", 32'(sel_onehot), 32'b010000);

    // Wrap in both directions and both-buttons conflict.
    $display("[TB] wrap and conflict");
    do_reset();
    press(1'b0, 3'd0, 3'd5);
    checkOutput("onehot_5", 32'(sel_onehot), 32'b100000);
    step(1);
    checkOutput("ds_src5", 32'(ds), 32'h600);
    step(10);
    press(1'b1, 3'd5, 3'd0);
    step(1);
    checkOutput("ds_src0_wrap", 32'(ds), 32'h100);
    step(10);
    applyStimulus(1'b1, 1'b1, 2'b00);
    for (int k = 0; k < 20; k++) begin
      step(1);
      checkOutput("sel_both", 32'(sel_idx), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 2'b00);
    step(2);
    press(1'b1, 3'd0, 3'd1);

    // Walk patterns at selection 3.
    $display("[TB] walk modes");
    do_reset();
    press(1'b1, 3'd0, 3'd1);
    step(10);
    press(1'b1, 3'd1, 3'd2);
    step(10);
    press(1'b1, 3'd2, 3'd3);
    for (int i = 0; i < 12; i++) walk_step(DW'(1) << i);
    walk_step(12'h000);
    walk_step(12'h001);
    for (int i = 1; i < 12; i++) walk_step(DW'(1) << i);
    walk_step(12'h000);
    applyStimulus(1'b0, 1'b0, 2'b01);
    walk_step(12'h800);
    for (int i = 10; i >= 0; i--) walk_step(DW'(1) << i);
    walk_step(12'h000);
    applyStimulus(1'b0, 1'b0, 2'b10);
    for (int i = 0; i < 12; i++) walk_step(DW'(1) << i);
    for (int i = 10; i >= 0; i--) walk_step(DW'(1) << i);
    walk_step(12'h002);
    applyStimulus(1'b0, 1'b0, 2'b11);
    for (int i = 0; i < 4092; i++) begin
      wait_tick();
      step(1);
    end
    checkOutput("count_fffe", 32'(walk), 32'hFFE);
    walk_step(12'hFFF);
    walk_step(12'h000);
    walk_step(12'h001);
    applyStimulus(1'b0, 1'b0, 2'b00);
    walk_step(12'h002);
    walk_step(12'h004);
    walk_step(12'h008);
    walk_step(12'h010);

    // Freeze while another source is shown, then resume.
    $display("[TB] walk freeze");
    wait_tick();
    step(1);
    checkOutput("walk_20", 32'(walk), 32'h020);
    applyStimulus(1'b1, 1'b0, 2'b00);
    step(1);
    applyStimulus(1'b0, 1'b0, 2'b00);
    step(2);
    checkOutput("sel_4", 32'(sel_idx), 32'd4);
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      step(1);
      checkOutput("walk_frozen", 32'(walk), 32'h020);
      if (i == 0) checkOutput("ds_src4", 32'(ds), 32'h500);
    end
    step(4);
    press(1'b0, 3'd4, 3'd3);
    walk_step(12'h040);

    // Reset mid-walk.
    $display("[TB] reset mid-walk");
    reset = 1'b1;
    step(1);
    checkOutput("mid_rst_walk", 32'(walk), 32'h0);
    checkOutput("mid_rst_sel", 32'(sel_idx), 32'd0);
    checkOutput("mid_rst_ds", 32'(ds), 32'h0);
    checkOutput("mid_rst_onehot", 32'(sel_onehot), 32'b000001);
    checkOutput("mid_rst_tick", 32'(tick), 32'd0);
    reset = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
